// File: rtl/gate_ex_pkg.sv
// -----------------------------------------------------------------------------
// gate_ex_pkg
// Shared definitions for the gate exerciser:
//   - FSM state encoding
//   - bit positions of the 7-bit returned gate vector {ny,ay,oy,nay,noy,xoy,xny}
//   - expected gate responses for the four {a,b} stimulus vectors
//   - a saturating increment helper for the mismatch counter
// -----------------------------------------------------------------------------
package gate_ex_pkg;

    // Sweep controller states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } gx_state_e;

    // Width and bit order of the returned gate vector, MSB first:
    // {ny, ay, oy, nay, noy, xoy, xny}.
    localparam int unsigned OUT_W   = 7;
    localparam int unsigned BIT_NY  = 6;
    localparam int unsigned BIT_AY  = 5;
    localparam int unsigned BIT_OY  = 4;
    localparam int unsigned BIT_NAY = 3;
    localparam int unsigned BIT_NOY = 2;
    localparam int unsigned BIT_XOY = 1;
    localparam int unsigned BIT_XNY = 0;

    // Expected gate vector for each stimulus {a,b}.
    localparam logic [OUT_W-1:0] EXP_AB_00 = 7'b1001101;
    localparam logic [OUT_W-1:0] EXP_AB_01 = 7'b1011010;
    localparam logic [OUT_W-1:0] EXP_AB_10 = 7'b0011010;
    localparam logic [OUT_W-1:0] EXP_AB_11 = 7'b0110001;

    // Index of the last vector in a sweep.
    localparam logic [1:0] LAST_IDX = 2'd3;

    // Saturating 3-bit increment; the counter tops out at 4 in practice,
    // saturation just keeps a corrupted count from wrapping back to zero.
    function automatic logic [2:0] sat_inc3(input logic [2:0] v);
        logic [2:0] r;
        if (v == 3'd7) begin
            r = v;
        end else begin
            r = v + 3'd1;
        end
        return r;
    endfunction

endpackage : gate_ex_pkg

// File: rtl/gate_expect.sv
// -----------------------------------------------------------------------------
// gate_expect
// Combinational lookup of the expected gate-block response for a sweep index.
// The index maps directly to the stimulus: a = idx[1], b = idx[0].
// Ports:
//   idx [1:0]  sweep index (stimulus vector number)
//   exp [6:0]  expected {ny,ay,oy,nay,noy,xoy,xny}
// -----------------------------------------------------------------------------
module gate_expect
    import gate_ex_pkg::*;
(
    input  logic [1:0]       idx,
    output logic [OUT_W-1:0] exp
);

    // Truth-table lookup for the current vector.
    always_comb begin
        exp = EXP_AB_00;
        case (idx)
            2'd0:    exp = EXP_AB_00;
            2'd1:    exp = EXP_AB_01;
            2'd2:    exp = EXP_AB_10;
            2'd3:    exp = EXP_AB_11;
            default: exp = EXP_AB_00;
        endcase
    end

endmodule : gate_expect

// File: rtl/gate_exerciser.sv
// -----------------------------------------------------------------------------
// gate_exerciser
// Drives the four {a,b} input combinations into an external 2-input gate block,
// waits SETTLE cycles for each, then compares the seven returned gate outputs
// against the expected truth table and accumulates the result.
//
// Parameters:
//   SETTLE   cycles spent in SETTLE per vector before the CHECK cycle (1..15)
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   start    one-cycle sweep request, accepted in IDLE or DONE only
//   a, b     registered stimulus to the gate block
//   ny..xny  gate block outputs under test
//   busy     sweep in progress
//   done     sweep finished; held until the next accepted start or reset
//   pass     valid with done; 1 when no vector mismatched
//   err_cnt  number of vectors with at least one mismatching output
//   err_vec  sticky OR of mismatch bits, ordered {ny,ay,oy,nay,noy,xoy,xny}
//
// Timing: each vector occupies SETTLE cycles in SETTLE plus one CHECK cycle,
// so done rises 4*(SETTLE+1) cycles after the start-accept edge.
// -----------------------------------------------------------------------------
module gate_exerciser
    import gate_ex_pkg::*;
#(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic       ny,
    input  logic       ay,
    input  logic       oy,
    input  logic       nay,
    input  logic       noy,
    input  logic       xoy,
    input  logic       xny,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_cnt,
    output logic [6:0] err_vec
);

    // Settle counter value on which SETTLE hands over to CHECK.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    gx_state_e        state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [2:0]       err_cnt_q, err_cnt_d;
    logic [OUT_W-1:0] err_vec_q, err_vec_d;

    logic [OUT_W-1:0] obs_s;
    logic [OUT_W-1:0] exp_s;
    logic [OUT_W-1:0] mism_s;
    logic [2:0]       err_cnt_upd_s;
    logic [OUT_W-1:0] err_vec_upd_s;

    gate_expect u_expect (
        .idx (idx_q),
        .exp (exp_s)
    );

    // Gather the returned gate outputs in the shared bit order and find mismatches.
    always_comb begin
        obs_s          = '0;
        obs_s[BIT_NY]  = ny;
        obs_s[BIT_AY]  = ay;
        obs_s[BIT_OY]  = oy;
        obs_s[BIT_NAY] = nay;
        obs_s[BIT_NOY] = noy;
        obs_s[BIT_XOY] = xoy;
        obs_s[BIT_XNY] = xny;
        mism_s         = obs_s ^ exp_s;
    end

    // Error accumulation for the vector under check; only committed in CHECK.
    always_comb begin
        err_cnt_upd_s = err_cnt_q;
        err_vec_upd_s = err_vec_q | mism_s;
        if (mism_s != 7'd0) begin
            err_cnt_upd_s = sat_inc3(err_cnt_q);
        end else begin
            err_cnt_upd_s = err_cnt_q;
        end
    end

    // Next-state and next-output logic for the sweep controller.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        err_cnt_d = err_cnt_q;
        err_vec_d = err_vec_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // a/b keep their last values here; a new start restarts at 00.
                if (start) begin
                    state_d   = ST_SETTLE;
                    idx_d     = 2'd0;
                    cnt_d     = 4'd0;
                    a_d       = 1'b0;
                    b_d       = 1'b0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    err_cnt_d = 3'd0;
                    err_vec_d = 7'd0;
                end else begin
                    state_d = state_q;
                end
            end

            ST_SETTLE: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_CHECK;
                end else begin
                    state_d = ST_SETTLE;
                end
            end

            ST_CHECK: begin
                err_cnt_d = err_cnt_upd_s;
                err_vec_d = err_vec_upd_s;
                if (idx_q != LAST_IDX) begin
                    state_d        = ST_SETTLE;
                    idx_d          = idx_q + 2'd1;
                    {a_d, b_d}     = idx_q + 2'd1;
                    cnt_d          = 4'd0;
                end else begin
                    // Pass is judged on the count that includes this last vector.
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_cnt_upd_s == 3'd0);
                end
            end

            default: begin
                // Unreachable encoding: fall back to a quiet idle.
                state_d   = ST_IDLE;
                idx_d     = 2'd0;
                cnt_d     = 4'd0;
                busy_d    = 1'b0;
                done_d    = 1'b0;
                pass_d    = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= 2'd0;
            cnt_q     <= 4'd0;
            a_q       <= 1'b0;
            b_q       <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_cnt_q <= 3'd0;
            err_vec_q <= 7'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            err_cnt_q <= err_cnt_d;
            err_vec_q <= err_vec_d;
        end
    end

    assign a       = a_q;
    assign b       = b_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign pass    = pass_q;
    assign err_cnt = err_cnt_q;
    assign err_vec = err_vec_q;

endmodule : gate_exerciser
